// File: rtl/exu_alu_arb.sv
// Two-requester issue arbiter for a shared ALU: starvation override, optional branch priority
// (EXU_ALU_ARB_BR_PRIO_EN), round-robin otherwise, plus a one-deep in-flight tag for the response.
module exu_alu_arb #(
    parameter int PW         = 107,
    parameter int APW        = 24,
    parameter int STARVE_MAX = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           freeze,
    input  logic           flush,
    input  logic           req0_valid,
    input  logic           req1_valid,
    input  logic           req0_br,
    input  logic           req1_br,
    input  logic [PW-1:0]  req0_data,
    input  logic [PW-1:0]  req1_data,
    input  logic [APW-1:0] req0_ap,
    input  logic [APW-1:0] req1_ap,
    output logic           req0_ready,
    output logic           req1_ready,
    output logic           alu_valid,
    output logic           alu_enable,
    output logic [PW-1:0]  alu_data,
    output logic [APW-1:0] alu_ap,
    input  logic           alu_flush_upper,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [3:0]     starve0,
    output logic [3:0]     starve1
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] STARVE_SAT = 4'hF;

    logic           blocked;
    logic           contend;
    logic           win1;
    logic           grant;
    logic           gnt0;
    logic           gnt1;

    logic [APW-1:0] ap_q,      ap_d;
    logic           inf_v_q,   inf_v_d;
    logic           inf_id_q,  inf_id_d;
    logic           rr_q,      rr_d;
    logic [3:0]     starve0_q, starve0_d;
    logic [3:0]     starve1_q, starve1_d;

`ifndef EXU_ALU_ARB_BR_PRIO_EN
    logic br_unused;
    assign br_unused = req0_br ^ req1_br;
`endif

    // The ALU's own branch flush also stalls issue, so a killed op never overlaps a new one.
    assign blocked = freeze | flush | alu_flush_upper;
    assign contend = req0_valid & req1_valid;
    assign grant   = ~blocked & (req0_valid | req1_valid);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win1 = req1_valid;
        if (contend) begin
            if (starve0_q >= STARVE_LIM) begin
                win1 = 1'b0;
            end else if (starve1_q >= STARVE_LIM) begin
                win1 = 1'b1;
`ifdef EXU_ALU_ARB_BR_PRIO_EN
            end else if (req0_br != req1_br) begin
                win1 = req1_br;
`endif
            end else begin
                win1 = rr_q;
            end
        end
    end

    assign gnt0       = grant & ~win1;
    assign gnt1       = grant &  win1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign alu_valid  = grant;
    assign alu_enable = grant;
    assign alu_data   = win1 ? req1_data : req0_data;

    always_comb begin
        ap_d      = ap_q;
        rr_d      = rr_q;
        inf_v_d   = 1'b0;
        inf_id_d  = inf_id_q;
        starve0_d = starve0_q;
        starve1_d = starve1_q;

        if (grant) begin
            ap_d = win1 ? req1_ap : req0_ap;
        end
        // The pointer prefers whoever just lost a contended grant.
        if (grant && contend) begin
            rr_d = ~win1;
        end

        if (gnt0) begin
            starve0_d = '0;
        end else if (req0_valid && gnt1 && starve0_q != STARVE_SAT) begin
            starve0_d = starve0_q + 4'd1;
        end
        if (gnt1) begin
            starve1_d = '0;
        end else if (req1_valid && gnt0 && starve1_q != STARVE_SAT) begin
            starve1_d = starve1_q + 4'd1;
        end

        // Flush outranks freeze; freeze parks the tag so the response emerges once it lifts.
        if (flush) begin
            inf_v_d = 1'b0;
        end else if (freeze) begin
            inf_v_d = inf_v_q;
        end else if (grant) begin
            inf_v_d  = 1'b1;
            inf_id_d = win1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ap_q      <= '0;
            inf_v_q   <= 1'b0;
            inf_id_q  <= 1'b0;
            rr_q      <= 1'b0;
            starve0_q <= '0;
            starve1_q <= '0;
        end else begin
            ap_q      <= ap_d;
            inf_v_q   <= inf_v_d;
            inf_id_q  <= inf_id_d;
            rr_q      <= rr_d;
            starve0_q <= starve0_d;
            starve1_q <= starve1_d;
        end
    end

    assign alu_ap    = ap_q;
    assign rsp_valid = inf_v_q & ~freeze;
    assign rsp_id    = inf_id_q;
    assign starve0   = starve0_q;
    assign starve1   = starve1_q;

endmodule

// File: tb/tb_exu_alu_arb.sv
// Directed bench for exu_alu_arb: arbitration order, starvation, freeze/flush/flush_upper, reset.
module tb_exu_alu_arb;

    localparam int PW  = 107;
    localparam int APW = 24;

    localparam logic [PW-1:0]  D0  = 107'h0123_4567_89AB_CDEF_0246_8ACE;
    localparam logic [PW-1:0]  D1  = 107'h7_FEDC_BA98_7654_3210_1357_9BDF;
    localparam logic [APW-1:0] AP0 = 24'hA5A5A5;
    localparam logic [APW-1:0] AP1 = 24'h5A5A5A;
    localparam logic [APW-1:0] AP2 = 24'h3C3C3C;

    logic           clk = 1'b0;
    logic           rst;
    logic           freeze, flush, alu_flush_upper;
    logic           req0_valid, req1_valid, req0_br, req1_br;
    logic [PW-1:0]  req0_data, req1_data;
    logic [APW-1:0] req0_ap, req1_ap;
    logic           req0_ready, req1_ready, alu_valid, alu_enable;
    logic [PW-1:0]  alu_data;
    logic [APW-1:0] alu_ap;
    logic           rsp_valid, rsp_id;
    logic [3:0]     starve0, starve1;

    int n_cmp = 0;
    int n_err = 0;

    exu_alu_arb #(.PW(PW), .APW(APW), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_br(req0_br), .req1_br(req1_br),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_ap(req0_ap), .req1_ap(req1_ap),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .alu_valid(alu_valid), .alu_enable(alu_enable),
        .alu_data(alu_data), .alu_ap(alu_ap),
        .alu_flush_upper(alu_flush_upper),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .starve0(starve0), .starve1(starve1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze = 0; flush = 0; alu_flush_upper = 0;
        req0_valid = 0; req1_valid = 0; req0_br = 0; req1_br = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        req0_ap = AP0; req1_ap = AP1;
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    initial begin
        logic [4:0] exp_g;
        logic [3:0] exp_s0 [5];

        idle_inputs();
        rst = 1;
        req0_data = D0; req1_data = D1; req0_ap = AP0; req1_ap = AP1;
        tick(); tick();

        // Reset state
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_alu_ap", alu_ap, 0);
        check("rst_starve0", starve0, 0);
        check("rst_starve1", starve1, 0);
        rst = 0; #1;
        check("idle_ready0", req0_ready, 0);
        check("idle_ready1", req1_ready, 0);
        check("idle_alu_valid", alu_valid, 0);
        check("idle_alu_enable", alu_enable, 0);

        // Round-robin with both requesters valid
        req0_valid = 1; req1_valid = 1; #1;
        check("rr1_ready0", req0_ready, 1);
        check("rr1_ready1", req1_ready, 0);
        check("rr1_alu_data", alu_data, D0);
        check("rr1_alu_valid", alu_valid, 1);
        check("rr1_alu_enable", alu_enable, 1);
        tick();
        check("rr2_rsp_valid", rsp_valid, 1);
        check("rr2_rsp_id", rsp_id, 0);
        check("rr2_alu_ap", alu_ap, AP0);
        check("rr2_ready1", req1_ready, 1);
        check("rr2_ready0", req0_ready, 0);
        check("rr2_alu_data", alu_data, D1);
        tick();
        check("rr3_rsp_id", rsp_id, 1);
        check("rr3_alu_ap", alu_ap, AP1);
        check("rr3_ready0", req0_ready, 1);
        tick();
        check("rr4_rsp_id", rsp_id, 0);
        check("rr4_ready1", req1_ready, 1);
        tick();
        check("rr5_rsp_valid", rsp_valid, 1);
        check("rr5_rsp_id", rsp_id, 1);
        check("rr5_starve0", starve0, 1);
        check("rr5_starve1", starve1, 0);
        req0_valid = 0; req1_valid = 0; #1;
        check("rr5_idle_ready0", req0_ready, 0);
        check("rr5_idle_alu_valid", alu_valid, 0);
        tick();
        check("rr6_rsp_valid", rsp_valid, 0);
        check("rr6_alu_ap_hold", alu_ap, AP1);

        // Starvation / branch priority: req1 always br, req0 never
        do_reset();
`ifdef EXU_ALU_ARB_BR_PRIO_EN
        exp_g = 5'b10111;  // cycle 1 in bit 0: grants 1,1,1,0,1
        exp_s0[0] = 0; exp_s0[1] = 1; exp_s0[2] = 2; exp_s0[3] = 3; exp_s0[4] = 0;
`else
        exp_g = 5'b01010;  // br ignored: grants 0,1,0,1,0
        exp_s0[0] = 0; exp_s0[1] = 0; exp_s0[2] = 1; exp_s0[3] = 0; exp_s0[4] = 1;
`endif
        req0_valid = 1; req1_valid = 1; req1_br = 1; #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sv%0d_starve0", i + 1), starve0, exp_s0[i]);
            check($sformatf("sv%0d_ready1", i + 1), req1_ready, exp_g[i]);
            check($sformatf("sv%0d_ready0", i + 1), req0_ready, !exp_g[i]);
            tick();
        end
        check("sv_end_starve1", starve1, exp_g[4] ? 0 : 1);

        // Freeze across the response cycle
        do_reset();
        req1_valid = 1; #1;
        check("fz_grant_ready1", req1_ready, 1);
        tick();
        freeze = 1; req0_valid = 1; req1_ap = AP2; #1;
        check("fz1_rsp_valid", rsp_valid, 0);
        check("fz1_ready0", req0_ready, 0);
        check("fz1_ready1", req1_ready, 0);
        check("fz1_alu_valid", alu_valid, 0);
        check("fz1_alu_enable", alu_enable, 0);
        check("fz1_alu_ap", alu_ap, AP1);
        tick();
        check("fz2_rsp_valid", rsp_valid, 0);
        check("fz2_ready1", req1_ready, 0);
        check("fz2_alu_ap", alu_ap, AP1);
        freeze = 0; req0_valid = 0; req1_valid = 0; #1;
        check("fz3_rsp_valid", rsp_valid, 1);
        check("fz3_rsp_id", rsp_id, 1);
        check("fz3_alu_ap", alu_ap, AP1);
        tick();
        check("fz4_rsp_valid", rsp_valid, 0);

        // ALU branch flush blocks the next grant
        do_reset();
        req1_valid = 1; #1;
        check("fu_grant_ready1", req1_ready, 1);
        tick();
        alu_flush_upper = 1; req0_valid = 1; #1;
        check("fu_ready0", req0_ready, 0);
        check("fu_ready1", req1_ready, 0);
        check("fu_alu_valid", alu_valid, 0);
        check("fu_rsp_valid", rsp_valid, 1);
        check("fu_rsp_id", rsp_id, 1);
        tick();
        alu_flush_upper = 0; #1;
        check("fu_resume_ready0", req0_ready, 1);
        check("fu_resume_alu_valid", alu_valid, 1);
        check("fu_resume_rsp_valid", rsp_valid, 0);

        // Pipeline flush in the response cycle
        do_reset();
        req0_valid = 1; #1;
        tick();
        flush = 1; req1_valid = 1; #1;
        check("fl_ready0", req0_ready, 0);
        check("fl_ready1", req1_ready, 0);
        check("fl_rsp_valid_n1", rsp_valid, 1);
        tick();
        flush = 0; req0_valid = 0; req1_valid = 0; #1;
        check("fl_rsp_valid_n2", rsp_valid, 0);

        // Flush and freeze together: flush wins
        req0_valid = 1; #1;
        tick();
        req0_valid = 0; freeze = 1; flush = 1; #1;
        check("ff_rsp_valid_during", rsp_valid, 0);
        tick();
        freeze = 0; flush = 0; #1;
        check("ff_rsp_valid_after", rsp_valid, 0);

        // Reset in the cycle after a contended grant
        do_reset();
        req0_valid = 1; req1_valid = 1; #1;
        check("rs_grant_ready0", req0_ready, 1);
        tick();
        check("rs_pre_starve1", starve1, 1);
        check("rs_pre_alu_ap", alu_ap, AP0);
        rst = 1;
        tick();
        rst = 0; req0_valid = 0; req1_valid = 0; #1;
        check("rs_rsp_valid", rsp_valid, 0);
        check("rs_starve0", starve0, 0);
        check("rs_starve1", starve1, 0);
        check("rs_alu_ap", alu_ap, 0);
        req0_valid = 1; req1_valid = 1; #1;
        check("rs_rr_ready0", req0_ready, 1);
        check("rs_rr_ready1", req1_ready, 0);
        tick();
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
